// File: rtl/mult_add_param.sv
// Sequential shift-add multiply-accumulate: product = multiplicand * multiplier + addend,
// one multiplier bit per clock; reconstructs a dividend from divider quotient/divisor/remainder.
module mult_add_param #(
  parameter int unsigned BITSIZE   = 16,
  parameter int unsigned INDEXSIZE = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   strt,
  input  logic [BITSIZE-1:0]     multiplicand,
  input  logic [BITSIZE-1:0]     multiplier,
  input  logic [BITSIZE-1:0]     addend,
  output logic [2*BITSIZE-1:0]   product,
  output logic                   overflow,
  output logic                   done,
  output logic                   idle
);

  localparam int unsigned PW = 2 * BITSIZE;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CALC     = 2'd1,
    POSTCALC = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [PW-1:0]        acc_q, acc_d;
  logic [PW-1:0]        mcand_q, mcand_d;
  logic [BITSIZE-1:0]   mplier_q, mplier_d;
  logic [INDEXSIZE-1:0] cnt_q, cnt_d;
  logic [PW-1:0]        product_q, product_d;
  logic                 overflow_q, overflow_d;
  logic                 done_q, done_d;

  // Next-state and datapath; operands are captured only on a start from IDLE.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    cnt_d      = cnt_q;
    product_d  = product_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (strt) begin
          acc_d    = {{BITSIZE{1'b0}}, addend};
          mcand_d  = {{BITSIZE{1'b0}}, multiplicand};
          mplier_d = multiplier;
          cnt_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + INDEXSIZE'(1);
        if (cnt_q == INDEXSIZE'(BITSIZE - 1)) begin
          state_d = POSTCALC;
        end
      end
      POSTCALC: begin
        product_d  = acc_q;
        overflow_d = |acc_q[PW-1:BITSIZE];
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset aborts any operation and clears the result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      cnt_q      <= '0;
      product_q  <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      cnt_q      <= cnt_d;
      product_q  <= product_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign product  = product_q;
  assign overflow = overflow_q;
  assign done     = done_q;
  assign idle     = (state_q == IDLE);

endmodule

// File: tb/tb_mult_add_param.sv
// Directed and round-trip checks for the shift-add multiply-accumulate unit.
module tb_mult_add_param;

  logic        clk;
  logic        rst;
  logic        strt;
  logic [15:0] mc, mp, ad;
  logic [31:0] product;
  logic        overflow, done, idle;

  int n_vec;
  int n_err;

  mult_add_param #(.BITSIZE(16), .INDEXSIZE(4)) dut (
    .clk(clk), .rst(rst), .strt(strt),
    .multiplicand(mc), .multiplier(mp), .addend(ad),
    .product(product), .overflow(overflow), .done(done), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] mcand;
    logic [15:0] mplier;
    logic [15:0] add;
    logic [31:0] exp_p;
    logic        exp_o;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Issue one start pulse; returns after edge E0.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    @(negedge clk);
    mc = a; mp = b; ad = c; strt = 1'b1;
    @(posedge clk);
    #1 strt = 1'b0;
  endtask

  // Full operation with latency, result and done-pulse checks.
  task automatic run_op(input string nm, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [31:0] ep, input logic eo);
    int edges;
    start_op(a, b, c);
    edges = 0;
    while (edges < 40) begin
      @(posedge clk);
      #1 edges++;
      if (done) break;
    end
    check({nm, " latency"}, 64'(edges), 64'd17);
    check({nm, " product"}, 64'(product), 64'(ep));
    check({nm, " overflow"}, 64'(overflow), 64'(eo));
    check({nm, " idle"}, 64'(idle), 64'd1);
    @(posedge clk);
    #1 check({nm, " done_low"}, 64'(done), 64'd0);
  endtask

  initial begin
    int ndone, e1, e2;
    logic [15:0] dvd, dvs, q, r;

    vecs[0]  = '{16'd7,     16'd9,      16'd5,      32'h0000_0044, 1'b0};
    vecs[1]  = '{16'hFFFF,  16'hFFFF,   16'hFFFF,   32'hFFFF_0000, 1'b1};
    vecs[2]  = '{16'h0000,  16'h1234,   16'h00AB,   32'h0000_00AB, 1'b0};
    vecs[3]  = '{16'd7,     16'd142,    16'd6,      32'd1000,      1'b0};
    vecs[4]  = '{16'd1,     16'd1,      16'd0,      32'd1,         1'b0};
    vecs[5]  = '{16'h0100,  16'h0100,   16'h0000,   32'h0001_0000, 1'b1};
    vecs[6]  = '{16'hFFFF,  16'h0001,   16'hFFFF,   32'h0001_FFFE, 1'b1};
    vecs[7]  = '{16'h00FF,  16'h0101,   16'h0000,   32'h0000_FFFF, 1'b0};
    vecs[8]  = '{16'h1234,  16'h0000,   16'h5678,   32'h0000_5678, 1'b0};
    vecs[9]  = '{16'd100,   16'd100,    16'd0,      32'h0000_2710, 1'b0};
    vecs[10] = '{16'h8000,  16'h0002,   16'h0000,   32'h0001_0000, 1'b1};
    vecs[11] = '{16'hFFFF,  16'hFFFF,   16'h0000,   32'hFFFE_0001, 1'b1};

    n_vec = 0; n_err = 0;
    strt = 1'b0; mc = '0; mp = '0; ad = '0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset product", 64'(product), 64'd0);
    check("reset overflow", 64'(overflow), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset idle", 64'(idle), 64'd1);
    @(negedge clk) rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].mcand, vecs[i].mplier, vecs[i].add,
             vecs[i].exp_p, vecs[i].exp_o);
    end

    // strt and operand changes while busy must be ignored.
    start_op(16'd3, 16'd4, 16'd1);
    ndone = 0; e1 = 0;
    for (int e = 1; e <= 25; e++) begin
      @(posedge clk);
      #1;
      if (done) begin ndone++; e1 = e; end
      if (e == 5) begin strt = 1'b1; mc = 16'hFFFF; mp = 16'hFFFF; ad = 16'hFFFF; end
      if (e == 6) strt = 1'b0;
    end
    check("busy done_count", 64'(ndone), 64'd1);
    check("busy done_edge", 64'(e1), 64'd17);
    check("busy product", 64'(product), 64'd13);
    check("busy idle", 64'(idle), 64'd1);

    // strt held high restarts on every return to IDLE.
    @(negedge clk);
    mc = 16'd2; mp = 16'd3; ad = 16'd1; strt = 1'b1;
    ndone = 0; e1 = 0; e2 = 0;
    for (int e = 0; e <= 36; e++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        if (ndone == 1) e1 = e; else e2 = e;
      end
    end
    strt = 1'b0;
    check("hold done_count", 64'(ndone), 64'd2);
    check("hold first_edge", 64'(e1), 64'd17);
    check("hold second_edge", 64'(e2), 64'd35);
    check("hold product", 64'(product), 64'd7);
    e1 = 0;
    while (e1 < 25 && !done) begin
      @(posedge clk);
      #1 e1++;
    end
    check("hold drain_done", 64'(done), 64'd1);
    @(posedge clk);

    // Asynchronous reset mid-operation discards everything at once.
    start_op(16'd100, 16'd100, 16'd0);
    repeat (8) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("midrst product", 64'(product), 64'd0);
    check("midrst done", 64'(done), 64'd0);
    check("midrst idle", 64'(idle), 64'd1);
    @(negedge clk) rst = 1'b1;
    run_op("after_rst", 16'd2, 16'd3, 16'd1, 32'd7, 1'b0);

    // Divider round trip on random pairs.
    for (int i = 0; i < 8; i++) begin
      dvs = 16'($urandom_range(1, 65535));
      dvd = 16'($urandom_range(0, 65535));
      q = dvd / dvs;
      r = dvd % dvs;
      run_op($sformatf("round%0d", i), dvs, q, r, {16'h0000, dvd}, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
